// File: rtl/sensor_pwr_pkg.sv
// ---------------------------------------------------------------------------
// sensor_pwr_pkg
// Shared definitions for the image-sensor power sequencer:
//   - default parameter values (rail count, counter width, delays)
//   - pwr_state_e : 4-bit FSM state encoding, identical to the state_o readback
//   - is_busy()   : which states count as "sequencing in progress"
// ---------------------------------------------------------------------------
package sensor_pwr_pkg;

  localparam int NUM_RAILS_DEF  = 3;
  localparam int DLY_W_DEF      = 24;
  localparam int PG_TIMEOUT_DEF = 500000;
  localparam int INCK_DLY_DEF   = 1000;
  localparam int PD_DLY_DEF     = 1000;

  // The encoding is software-visible through the control PIO; keep it stable.
  // RAIL_UP and RAIL_DN are per-rail states; the rail index is held separately.
  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_RAIL_UP = 4'd1,
    ST_INCK_UP = 4'd2,
    ST_ON      = 4'd3,
    ST_PD_XCLR = 4'd4,
    ST_PD_INCK = 4'd5,
    ST_RAIL_DN = 4'd6,
    ST_FAULT   = 4'd7
  } pwr_state_e;

  function automatic logic is_busy(input pwr_state_e s);
    return (s == ST_RAIL_UP) || (s == ST_INCK_UP) || (s == ST_PD_XCLR) ||
           (s == ST_PD_INCK) || (s == ST_RAIL_DN);
  endfunction

endpackage

// File: rtl/sensor_pwr_seq_if.sv
// ---------------------------------------------------------------------------
// sensor_pwr_seq_if
// Control/status bundle between the control PIO + regulator board (master)
// and the power sequencer (slave).
//   master drives : en_i, clr_fault_i, dly_cfg_i, pgood_i
//   slave drives  : rail_en_o, inck_en_o, xclr_o, ready_o, busy_o, fault_o,
//                   state_o
// Signalling: there is no valid/ready pair on this bundle. en_i is a level
// (1 = power up / stay on, 0 = power down) sampled every clock; clr_fault_i
// is a single-cycle pulse, acted on only in the FAULT state with en_i=0;
// dly_cfg_i is sampled only on entry to a rail's power-up step; pgood_i is
// already synchronised to the sequencer clock. All slave outputs are
// registered.
// ---------------------------------------------------------------------------
interface sensor_pwr_seq_if
  import sensor_pwr_pkg::*;
#(
  parameter int NUM_RAILS = NUM_RAILS_DEF,
  parameter int DLY_W     = DLY_W_DEF
);

  logic                       en_i;
  logic                       clr_fault_i;
  logic [NUM_RAILS*DLY_W-1:0] dly_cfg_i;
  logic [NUM_RAILS-1:0]       pgood_i;

  logic [NUM_RAILS-1:0]       rail_en_o;
  logic                       inck_en_o;
  logic                       xclr_o;
  logic                       ready_o;
  logic                       busy_o;
  logic                       fault_o;
  logic [3:0]                 state_o;

  modport master (
    output en_i, clr_fault_i, dly_cfg_i, pgood_i,
    input  rail_en_o, inck_en_o, xclr_o, ready_o, busy_o, fault_o, state_o
  );

  modport slave (
    input  en_i, clr_fault_i, dly_cfg_i, pgood_i,
    output rail_en_o, inck_en_o, xclr_o, ready_o, busy_o, fault_o, state_o
  );

endinterface

// File: rtl/sensor_pwr_seq_dly_cnt.sv
// ---------------------------------------------------------------------------
// pwr_dly_cnt
// Loadable saturating down-counter used for settle, step and timeout delays.
//   clk, rst_n : clock, synchronous active-low reset (value clears to 0)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   value      : current count
//   zero       : value == 0; the counter holds at 0 until reloaded
// ---------------------------------------------------------------------------
module pwr_dly_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/sensor_pwr_seq.sv
// ---------------------------------------------------------------------------
// sensor_pwr_seq
// Power sequencer for the image-sensor front end. Enables NUM_RAILS regulators
// in index order (each must report power-good before its settle delay
// completes the step), then enables INCK, then releases XCLR. Power-down runs
// the same chain in reverse, skipping steps whose output was never asserted.
// Loss of power-good on any enabled rail while powering up or on drops every
// output at once and latches a sticky fault.
//
// Ports:
//   clk_clk       : system clock
//   reset_reset_n : synchronous active-low reset; all outputs go to 0
//   bus (slave)   : en_i, clr_fault_i, dly_cfg_i, pgood_i in;
//                   rail_en_o, inck_en_o, xclr_o, ready_o, busy_o, fault_o,
//                   state_o out (see sensor_pwr_seq_if)
//
// Delay convention: a wait of N cycles loads the counter with N-1, so the
// state is occupied for exactly N cycles and the step's output change lands
// N cycles after the previous one. A zero settle delay is treated as 1.
// ---------------------------------------------------------------------------
module sensor_pwr_seq
  import sensor_pwr_pkg::*;
#(
  parameter int NUM_RAILS  = NUM_RAILS_DEF,
  parameter int DLY_W      = DLY_W_DEF,
  parameter int PG_TIMEOUT = PG_TIMEOUT_DEF,
  parameter int INCK_DLY   = INCK_DLY_DEF,
  parameter int PD_DLY     = PD_DLY_DEF
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  sensor_pwr_seq_if.slave  bus
);

  localparam int      IDX_W   = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam longint  CNT_MAX = (longint'(1) << DLY_W) - 1;

  // Delay parameters below 1 behave as 1.
  localparam logic [DLY_W-1:0] PG_LD   = DLY_W'(((PG_TIMEOUT < 1) ? 1 : PG_TIMEOUT) - 1);
  localparam logic [DLY_W-1:0] INCK_LD = DLY_W'(((INCK_DLY < 1) ? 1 : INCK_DLY) - 1);
  localparam logic [DLY_W-1:0] PD_LD   = DLY_W'(((PD_DLY < 1) ? 1 : PD_DLY) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

  if (NUM_RAILS < 1) begin : g_bad_rails
    $error("sensor_pwr_seq: NUM_RAILS must be at least 1");
  end
  if (longint'(PG_TIMEOUT) > CNT_MAX) begin : g_bad_pg
    $error("sensor_pwr_seq: PG_TIMEOUT does not fit in DLY_W bits");
  end
  if (longint'(INCK_DLY) > CNT_MAX) begin : g_bad_inck
    $error("sensor_pwr_seq: INCK_DLY does not fit in DLY_W bits");
  end
  if (longint'(PD_DLY) > CNT_MAX) begin : g_bad_pd
    $error("sensor_pwr_seq: PD_DLY does not fit in DLY_W bits");
  end

  // ---------------------------------------------------------------- state
  pwr_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;       // current rail (up) / highest still on (down)
  logic [NUM_RAILS-1:0] rail_q, rail_d;
  logic                 inck_q, inck_d;
  logic                 xclr_q, xclr_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 fault_q, fault_d;

  // ------------------------------------------------------------- counters
  logic             step_ld, step_zero;
  logic [DLY_W-1:0] step_val, step_cnt;
  logic             tmo_ld, tmo_zero;
  logic [DLY_W-1:0] tmo_cnt;

  pwr_dly_cnt #(.W(DLY_W)) u_step_cnt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (step_ld),
    .load_val (step_val),
    .value    (step_cnt),
    .zero     (step_zero)
  );

  pwr_dly_cnt #(.W(DLY_W)) u_tmo_cnt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (tmo_ld),
    .load_val (PG_LD),
    .value    (tmo_cnt),
    .zero     (tmo_zero)
  );

  // Counter values are only of interest when inspecting waveforms.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{step_cnt, tmo_cnt};

  // ---------------------------------------------------------- datapath
  logic [IDX_W-1:0]     idx_nxt;
  logic [IDX_W-1:0]     cfg_idx;
  logic [DLY_W-1:0]     cfg_raw;
  logic [DLY_W-1:0]     settle_ld;
  logic [NUM_RAILS-1:0] cur_bit;
  logic                 rail_ok;
  logic                 pg_lost_up;
  logic                 pg_lost_all;

  assign idx_nxt = idx_q + IDX_W'(1);

  // The rail being entered: rail 0 when leaving OFF, otherwise the next one.
  assign cfg_idx   = (state_q == ST_OFF) ? '0 : idx_nxt;
  assign cfg_raw   = bus.dly_cfg_i[int'(cfg_idx)*DLY_W +: DLY_W];
  assign settle_ld = (cfg_raw == '0) ? '0 : cfg_raw - DLY_W'(1);

  assign cur_bit     = NUM_RAILS'(1) << idx_q;
  assign rail_ok     = step_zero && bus.pgood_i[idx_q];
  // While rail k is still coming up its own pgood is not yet monitored.
  assign pg_lost_up  = |(rail_q & ~bus.pgood_i & ~cur_bit);
  assign pg_lost_all = |(rail_q & ~bus.pgood_i);

  // ------------------------------------------------ next state / outputs
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rail_d   = rail_q;
    step_ld  = 1'b0;
    step_val = '0;
    tmo_ld   = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (bus.en_i && !fault_q) begin
          state_d   = ST_RAIL_UP;
          idx_d     = '0;
          rail_d[0] = 1'b1;
          step_ld   = 1'b1;
          step_val  = settle_ld;
          tmo_ld    = 1'b1;
        end
      end

      ST_RAIL_UP: begin
        // Fault first, then abort, then normal advance. A rail that is good
        // in the same cycle its timeout expires still advances.
        if (pg_lost_up || (tmo_zero && !rail_ok)) begin
          state_d = ST_FAULT;
        end else if (!bus.en_i) begin
          // Nothing past this rail was ever enabled: go straight to it.
          state_d       = ST_RAIL_DN;
          rail_d[idx_q] = 1'b0;
          step_ld       = 1'b1;
          step_val      = PD_LD;
        end else if (rail_ok) begin
          if (idx_q == LAST_IDX) begin
            state_d  = ST_INCK_UP;
            step_ld  = 1'b1;
            step_val = INCK_LD;
          end else begin
            idx_d           = idx_nxt;
            rail_d[idx_nxt] = 1'b1;
            step_ld         = 1'b1;
            step_val        = settle_ld;
            tmo_ld          = 1'b1;
          end
        end
      end

      ST_INCK_UP: begin
        if (pg_lost_all) begin
          state_d = ST_FAULT;
        end else if (!bus.en_i) begin
          // XCLR was never released, so its power-down step is skipped.
          state_d  = ST_PD_INCK;
          step_ld  = 1'b1;
          step_val = PD_LD;
        end else if (step_zero) begin
          state_d = ST_ON;
        end
      end

      ST_ON: begin
        if (pg_lost_all) begin
          state_d = ST_FAULT;
        end else if (!bus.en_i) begin
          state_d  = ST_PD_XCLR;
          step_ld  = 1'b1;
          step_val = PD_LD;
        end
      end

      ST_PD_XCLR: begin
        if (step_zero) begin
          state_d  = ST_PD_INCK;
          step_ld  = 1'b1;
          step_val = PD_LD;
        end
      end

      ST_PD_INCK: begin
        // idx_q still points at the last rail, which is the highest one on.
        if (step_zero) begin
          state_d       = ST_RAIL_DN;
          rail_d[idx_q] = 1'b0;
          step_ld       = 1'b1;
          step_val      = PD_LD;
        end
      end

      ST_RAIL_DN: begin
        if (step_zero) begin
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idx_d                   = idx_q - IDX_W'(1);
            rail_d[idx_q - IDX_W'(1)] = 1'b0;
            step_ld                 = 1'b1;
            step_val                = PD_LD;
          end
        end
      end

      ST_FAULT: begin
        if (bus.clr_fault_i && !bus.en_i) begin
          state_d = ST_OFF;
        end
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Fault shutdown drops every rail at once, no ordering.
    if (state_d == ST_FAULT) begin
      rail_d = '0;
    end

    inck_d  = (state_d == ST_INCK_UP) || (state_d == ST_ON) || (state_d == ST_PD_XCLR);
    xclr_d  = (state_d == ST_ON);
    ready_d = (state_d == ST_ON);
    busy_d  = is_busy(state_d);
    fault_d = (state_d == ST_FAULT);
  end

  // ----------------------------------------------------------- registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      rail_q  <= '0;
      inck_q  <= 1'b0;
      xclr_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rail_q  <= rail_d;
      inck_q  <= inck_d;
      xclr_q  <= xclr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign bus.rail_en_o = rail_q;
  assign bus.inck_en_o = inck_q;
  assign bus.xclr_o    = xclr_q;
  assign bus.ready_o   = ready_q;
  assign bus.busy_o    = busy_q;
  assign bus.fault_o   = fault_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_sensor_pwr_seq
// Directed bench for sensor_pwr_seq (3 rails, PG_TIMEOUT=100, INCK_DLY=20,
// PD_DLY=8). Each scenario pushes the output changes it expects, stamped with
// the clock cycle they must appear on, into exp_q. The monitor watches the
// output bundle on every falling edge: each change is popped and compared
// (value and cycle); an expected change whose cycle passes unseen is
// reported as missing. pgood_i[k] follows rail_en_o[k] five cycles later,
// with per-rail block and glitch overrides.
// ---------------------------------------------------------------------------
module tb_sensor_pwr_seq;
  import sensor_pwr_pkg::*;

  localparam int NR    = 3;
  localparam int DW    = 24;
  localparam int PG_TO = 100;
  localparam int INCK  = 20;
  localparam int PD    = 8;

  // ------------------------------------------------------ clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sensor_pwr_seq_if #(.NUM_RAILS(NR), .DLY_W(DW)) bus ();

  sensor_pwr_seq #(
    .NUM_RAILS  (NR),
    .DLY_W      (DW),
    .PG_TIMEOUT (PG_TO),
    .INCK_DLY   (INCK),
    .PD_DLY     (PD)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  // -------------------------------------------------------- pgood model
  logic [4:0]    pg_pipe [NR];
  logic [NR-1:0] pg_block = '0;
  logic [NR-1:0] pg_glitch = '0;
  logic [NR-1:0] pg_late;

  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) begin
      if (!rst_n) pg_pipe[k] = '0;
      else        pg_pipe[k] = {pg_pipe[k][3:0], bus.rail_en_o[k]};
    end
  end

  always_comb begin
    for (int k = 0; k < NR; k++) pg_late[k] = pg_pipe[k][4];
  end

  assign bus.pgood_i = pg_late & ~pg_block & ~pg_glitch;

  // --------------------------------------------------------- scoreboard
  // exp_q entry: {cycle[31:0], rail[2:0], inck, xclr, ready, busy, fault, state[3:0]}
  logic [43:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_en = 1'b0;
  logic        armed = 1'b0;
  logic [11:0] snap, prev_snap;
  logic [43:0] head;
  string       head_tag;

  always @(negedge clk) begin
    if (mon_en) begin
      snap = {bus.rail_en_o, bus.inck_en_o, bus.xclr_o, bus.ready_o,
              bus.busy_o, bus.fault_o, bus.state_o};
      if (!armed || snap != prev_snap) begin
        armed = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, snap);
        end else begin
          head     = exp_q.pop_front();
          head_tag = tag_q.pop_front();
          if (head != {cyc, snap}) begin
            n_errors++;
            $display("FAIL %s got cyc=%0d val=%h expected cyc=%0d val=%h",
                     head_tag, cyc, snap, head[43:12], head[11:0]);
          end
        end
        prev_snap = snap;
      end else if (exp_q.size() != 0 && exp_q[0][43:12] <= cyc) begin
        head     = exp_q.pop_front();
        head_tag = tag_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL %s missing: still val=%h at cyc=%0d expected cyc=%0d val=%h",
                 head_tag, snap, cyc, head[43:12], head[11:0]);
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int unsigned at, input logic [2:0] rail,
                           input logic inck, input logic xclr, input logic ready,
                           input logic busy, input logic fault,
                           input pwr_state_e st, input string tag);
    exp_q.push_back({at, rail, inck, xclr, ready, busy, fault, 4'(st)});
    tag_q.push_back(tag);
  endtask

  // From OFF to ON with settle delays 10/20/30; rail 1's delay is changed
  // mid-step to show it was sampled on entry.
  task automatic power_up();
    int unsigned c0;
    c0 = cyc;
    expect_at(c0 + 1,  3'b001, 0, 0, 0, 1, 0, ST_RAIL_UP, "up_rail0");
    expect_at(c0 + 11, 3'b011, 0, 0, 0, 1, 0, ST_RAIL_UP, "up_rail1");
    expect_at(c0 + 31, 3'b111, 0, 0, 0, 1, 0, ST_RAIL_UP, "up_rail2");
    expect_at(c0 + 61, 3'b111, 1, 0, 0, 1, 0, ST_INCK_UP, "up_inck");
    expect_at(c0 + 81, 3'b111, 1, 1, 1, 0, 0, ST_ON,      "up_on");
    bus.en_i = 1'b1;
    tick(15);
    bus.dly_cfg_i[47:24] = 24'd3;
    tick(20);
    bus.dly_cfg_i[47:24] = 24'd20;
    tick(50);
  endtask

  // ---------------------------------------------------------- stimulus
  int unsigned c0;

  initial begin
    bus.en_i        = 1'b0;
    bus.clr_fault_i = 1'b0;
    bus.dly_cfg_i   = {24'd30, 24'd20, 24'd10};
    rst_n           = 1'b0;
    tick(3);
    @(posedge clk);
    #1;
    expect_at(cyc, 3'b000, 0, 0, 0, 0, 0, ST_OFF, "reset_state");
    mon_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // Normal power-up, then orderly power-down. en_i pulses high during the
    // power-down and must be ignored.
    power_up();
    c0 = cyc;
    expect_at(c0 + 1,  3'b111, 1, 0, 0, 1, 0, ST_PD_XCLR, "pd_xclr");
    expect_at(c0 + 9,  3'b111, 0, 0, 0, 1, 0, ST_PD_INCK, "pd_inck");
    expect_at(c0 + 17, 3'b011, 0, 0, 0, 1, 0, ST_RAIL_DN, "pd_rail2");
    expect_at(c0 + 25, 3'b001, 0, 0, 0, 1, 0, ST_RAIL_DN, "pd_rail1");
    expect_at(c0 + 33, 3'b000, 0, 0, 0, 1, 0, ST_RAIL_DN, "pd_rail0");
    expect_at(c0 + 41, 3'b000, 0, 0, 0, 0, 0, ST_OFF,     "pd_off");
    bus.en_i = 1'b0;
    tick(12);
    bus.en_i = 1'b1;
    tick(18);
    bus.en_i = 1'b0;
    tick(20);

    // Abort during RAIL_UP(1): no XCLR/INCK steps, rail 2 never enabled.
    c0 = cyc;
    expect_at(c0 + 1,  3'b001, 0, 0, 0, 1, 0, ST_RAIL_UP, "abort_up_rail0");
    expect_at(c0 + 11, 3'b011, 0, 0, 0, 1, 0, ST_RAIL_UP, "abort_up_rail1");
    expect_at(c0 + 16, 3'b001, 0, 0, 0, 1, 0, ST_RAIL_DN, "abort_dn_rail1");
    expect_at(c0 + 24, 3'b000, 0, 0, 0, 1, 0, ST_RAIL_DN, "abort_dn_rail0");
    expect_at(c0 + 32, 3'b000, 0, 0, 0, 0, 0, ST_OFF,     "abort_off");
    bus.en_i = 1'b1;
    tick(15);
    bus.en_i = 1'b0;
    tick(30);

    // Power-good timeout on rail 1, then fault clear rules.
    pg_block = 3'b010;
    c0 = cyc;
    expect_at(c0 + 1,   3'b001, 0, 0, 0, 1, 0, ST_RAIL_UP, "tmo_rail0");
    expect_at(c0 + 11,  3'b011, 0, 0, 0, 1, 0, ST_RAIL_UP, "tmo_rail1");
    expect_at(c0 + 111, 3'b000, 0, 0, 0, 0, 1, ST_FAULT,   "tmo_fault");
    bus.en_i = 1'b1;
    tick(115);
    bus.clr_fault_i = 1'b1;    // en_i still 1: must be ignored
    tick(1);
    bus.clr_fault_i = 1'b0;
    tick(5);
    bus.en_i = 1'b0;           // en_i low alone does not leave FAULT
    tick(3);
    c0 = cyc;
    expect_at(c0 + 1, 3'b000, 0, 0, 0, 0, 0, ST_OFF, "tmo_clear");
    bus.clr_fault_i = 1'b1;
    tick(1);
    bus.clr_fault_i = 1'b0;
    pg_block = '0;
    tick(10);

    // One-cycle pgood glitch on rail 0 while ON.
    power_up();
    c0 = cyc;
    expect_at(c0 + 1, 3'b000, 0, 0, 0, 0, 1, ST_FAULT, "glitch_fault");
    pg_glitch = 3'b001;
    tick(1);
    pg_glitch = '0;
    tick(4);
    c0 = cyc;
    expect_at(c0 + 1, 3'b000, 0, 0, 0, 0, 0, ST_OFF, "glitch_clear");
    bus.en_i        = 1'b0;
    bus.clr_fault_i = 1'b1;
    tick(1);
    bus.clr_fault_i = 1'b0;
    tick(10);

    // Reset pulse while ON: straight to reset values, no ordering.
    power_up();
    c0 = cyc;
    expect_at(c0 + 1, 3'b000, 0, 0, 0, 0, 0, ST_OFF, "reset_in_on");
    rst_n = 1'b0;
    tick(1);
    rst_n    = 1'b1;
    bus.en_i = 1'b0;
    tick(10);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
